mod_add_one_1r_2c: RTL and testbench
====================================

# mod_add_one_1r_2c

Pipelined modular increment: each cycle it registers an operand `A` and a 1-bit carry-in `cin`, and produces `(A + cin)` reduced modulo the compile-time `MODULUS`. It is used as the carry-propagation and increment primitive inside the modular (residue) arithmetic datapaths of the error-correcting arithmetic engine. The sum is split into two carry-chunks across two register stages. This gives a fixed 2-cycle latency at full throughput (one operand per clock).

## Interface

Parameters:
- `DATA_WIDTH`, 18: operand and result width in bits; must be ≥ 2.
- `MODULUS`, 177147: modulus M; legal range 2 ≤ M ≤ 2^DATA_WIDTH. M = 2^DATA_WIDTH is legal and behaves as a plain wrapping increment.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `A`, input, DATA_WIDTH: operand, nominally in [0, M-1].
- `cin`, input, 1: increment amount (0 or 1). A wider driver is truncated to its LSB.
- `result`, output, DATA_WIDTH: registered modular sum.
- `range_err`, output, 1: present only when `MODADD_RANGE_CHK_EN` is defined (see Configuration).

## Operation

- Internal sum `S = A + cin`, computed at DATA_WIDTH+1 bits so there is no loss at A = 2^W - 1.
- If S ≥ M, then `result = S - M`; otherwise `result = S`. Truncate to DATA_WIDTH bits.
- Only one conditional subtraction is performed.
  - For in-range A (A < M), the result is exact: A + cin mod M.
  - For out-of-range A (A ≥ M), the behaviour is defined and deterministic, not a full reduction. Example with M=177147: A=261143, cin=0 gives 83996.
- Split datapath:
  - Let `L = DATA_WIDTH/2` (floor). This is the low chunk width; the high chunk is DATA_WIDTH-L bits.
  - Stage 1 registers the low L bits of S and of S-M, each with its chunk carry/borrow. It also registers the high bits of A and cin-derived context needed for stage 2.
  - Stage 2 completes the high chunk of S and S-M from the registered carries.
  - The select signal is "S-M did not borrow", i.e. S ≥ M.
  - Stage 2 drives `result` from a register.
- Constant M and its complement are elaborated from `MODULUS`. There are no runtime modulus inputs.
- No handshake: every clock edge accepts a new operand.

## Timing

- Latency is 2 cycles: operand sampled at rising edge N appears on `result` after edge N+2, and is stable until edge N+3.
- Throughput is 1 operand per cycle, with no bubbles and no stalls.
- Reset:
  - When `reset` = 1 at an edge, all pipeline registers, `result` and `range_err` clear to 0 at that edge.
  - The first real result appears 2 edges after the first sampled edge with `reset` = 0.
- Reset asserted mid-stream discards in-flight operands. There is no partial output: `result` shows 0 until refilled.
- Before the first reset, output values are undefined. Benches must reset first.
- Any input change between edges has no effect on outputs until sampled.

## Configuration

- `MODADD_RANGE_CHK_EN` defined:
  - Adds output `range_err`, registered and aligned with `result` (same 2-cycle latency).
  - `range_err` = 1 when the sampled A ≥ M; otherwise 0.
  - `result` behaviour is unchanged.
- `MODADD_RANGE_CHK_EN` undefined: there is no `range_err` port and no comparator logic.

## Test plan

All scenarios use DATA_WIDTH=18, M=177147 unless stated.

- Reset: hold `reset`=1 for 3 cycles, release, drive A=0, cin=0 → `result`=0 throughout reset and 2 cycles after; then 0.
- Back-to-back directed inputs, one per cycle:
  - (0,0) → 0
  - (177140,1) → 177141
  - (177146,1) → 0 (wrap)
  - (177146,0) → 177146
  - Each appears exactly 2 cycles after its input.
- Out-of-range inputs: (261143,0) → 83996; (262143,1) → 84997; (177147,0) → 0. With `MODADD_RANGE_CHK_EN`, `range_err`=1 for all three; for (177140,1), `range_err`=0.
- Streaming: for i = 0, 9, 18, … < 1000, drive A = (i·i) mod 2^18 and cin = i mod 2 on consecutive cycles. Compare every output against a reference model delayed by 2 cycles. Require zero mismatches and a mismatch count reported.
- Mid-stream reset: assert `reset` for 1 cycle while the pipeline is full → `result`=0 on the next 2 outputs, then correct results for the operands applied after release.
- Power-of-two modulus, M=262144: (262143,1) → 0; (5,1) → 6; (262143,0) → 262143.

Source files
------------

// File: rtl/mod_add_one_1r_2c.sv
// ---------------------------------------------------------------------------
// mod_add_one_1r_2c
//
// Pipelined modular increment: result = (A + cin) mod MODULUS, using a single
// conditional subtraction. The sum and the trial difference S-M are built in
// two carry chunks, the low chunk in stage 1 and the high chunk in stage 2.
// Each operand is first captured in an input register. Total latency is 2
// cycles after that sampling edge, with one operand accepted per clock.
//
// Parameters:
//   DATA_WIDTH  operand/result width (>= 2)
//   MODULUS     modulus M, 2 <= M <= 2**DATA_WIDTH
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset; clears every pipeline register
//   A          operand, nominally in [0, M-1]
//   cin        increment amount (0 or 1)
//   result     registered modular sum
//   range_err  registered flag, set when the sampled A >= M. This port exists
//              only when MODADD_RANGE_CHK_EN is defined.
//
// Optional feature macro: MODADD_RANGE_CHK_EN
// ---------------------------------------------------------------------------
module mod_add_one_1r_2c #(
  parameter int DATA_WIDTH = 18,
  parameter int MODULUS    = 177147
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] result
`ifdef MODADD_RANGE_CHK_EN
  ,
  output logic                  range_err
`endif
);

  // Low chunk width L and high chunk width H.
  localparam int L = DATA_WIDTH / 2;
  localparam int H = DATA_WIDTH - L;

  // M is held at DATA_WIDTH+1 bits so that M = 2**DATA_WIDTH is representable.
  localparam logic [DATA_WIDTH:0] MOD_C  = (DATA_WIDTH + 1)'(MODULUS);
  localparam logic [L-1:0]        MOD_LO = MOD_C[L-1:0];
  localparam logic [H:0]          MOD_HI = MOD_C[DATA_WIDTH:L];

  // Input register.
  logic [DATA_WIDTH-1:0] a_q;
  logic                  cin_q;

  // Stage 1 registers: low chunk of S and of S-M, plus their carry and borrow.
  logic [L-1:0] s_lo_q;
  logic         c_lo_q;
  logic [L-1:0] d_lo_q;
  logic         b_lo_q;
  logic [H-1:0] a_hi_q;

  // Stage 1 combinational low chunk.
  logic [L:0] lo_sum;
  logic [L:0] lo_diff;

  // Stage 2 combinational high chunk and select.
  logic [H:0]            hi_sum;
  logic [H-1:0]          hi_diff;
  logic                  no_borrow;
  logic [DATA_WIDTH-1:0] result_d;

  always_comb begin
    lo_sum  = {1'b0, a_q[L-1:0]} + {{L{1'b0}}, cin_q};
    // Bit L of lo_diff is the borrow out of the low chunk.
    lo_diff = {1'b0, lo_sum[L-1:0]} - {1'b0, MOD_LO};
  end

  always_comb begin
    // hi_sum[H] is bit DATA_WIDTH of S, so no carry is lost at A = 2**W-1.
    hi_sum    = {1'b0, a_hi_q} + {{H{1'b0}}, c_lo_q};
    // S >= M exactly when the full-width S-M does not borrow. The high chunk
    // is compared together with the low-chunk borrow.
    no_borrow = (hi_sum > MOD_HI) || ((hi_sum == MOD_HI) && !b_lo_q);
    // Only the low H bits of the high difference reach the result.
    hi_diff   = hi_sum[H-1:0] - MOD_HI[H-1:0] - {{(H-1){1'b0}}, b_lo_q};
    result_d  = no_borrow ? {hi_diff, d_lo_q} : {hi_sum[H-1:0], s_lo_q};
  end

  // Pipeline registers. Reset flushes every in-flight operand.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      cin_q  <= 1'b0;
      s_lo_q <= '0;
      c_lo_q <= 1'b0;
      d_lo_q <= '0;
      b_lo_q <= 1'b0;
      a_hi_q <= '0;
      result <= '0;
    end else begin
      a_q    <= A;
      cin_q  <= cin;
      s_lo_q <= lo_sum[L-1:0];
      c_lo_q <= lo_sum[L];
      d_lo_q <= lo_diff[L-1:0];
      b_lo_q <= lo_diff[L];
      a_hi_q <= a_q[DATA_WIDTH-1:L];
      result <= result_d;
    end
  end

`ifdef MODADD_RANGE_CHK_EN
  // The range flag travels alongside the datapath so it lines up with result.
  logic ge_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ge_q      <= 1'b0;
      range_err <= 1'b0;
    end else begin
      ge_q      <= ({1'b0, a_q} >= MOD_C);
      range_err <= ge_q;
    end
  end
`endif

endmodule

// File: tb/tb_mod_add_one_1r_2c.sv
// ---------------------------------------------------------------------------
// tb_mod_add_one_1r_2c
//
// Self-checking bench for mod_add_one_1r_2c. Two instances are driven with
// the same stimulus. The first uses M=177147 and the second uses M=262144,
// which is a power of two. Expected values come from a behavioural model and
// are queued when the stimulus is applied. Each value is popped and compared
// two edges later.
// ---------------------------------------------------------------------------
module tb_mod_add_one_1r_2c;

  localparam int W  = 18;
  localparam int M1 = 177147;
  localparam int M2 = 262144;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] a     = '0;
  logic         cin   = 1'b0;
  logic [W-1:0] res1;
  logic [W-1:0] res2;
`ifdef MODADD_RANGE_CHK_EN
  logic         rerr1;
  logic         rerr2;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    logic         re;
  } exp_t;

  exp_t sb[$];

  mod_add_one_1r_2c #(.DATA_WIDTH(W), .MODULUS(M1)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .A        (a),
    .cin      (cin),
    .result   (res1)
`ifdef MODADD_RANGE_CHK_EN
    ,
    .range_err(rerr1)
`endif
  );

  mod_add_one_1r_2c #(.DATA_WIDTH(W), .MODULUS(M2)) u_dut_pow2 (
    .clk      (clk),
    .reset    (reset),
    .A        (a),
    .cin      (cin),
    .result   (res2)
`ifdef MODADD_RANGE_CHK_EN
    ,
    .range_err(rerr2)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference: one conditional subtraction on a wide sum.
  function automatic logic [W-1:0] model(input logic [W-1:0] av, input logic c, input int m);
    longint s;
    s = longint'(av) + longint'(c);
    if (s >= longint'(m)) s = s - longint'(m);
    return s[W-1:0];
  endfunction

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus, update the scoreboard, and check the output.
  task automatic applyStimulus(input logic [W-1:0] av, input logic c, input logic r, input string tag);
    exp_t e;
    @(negedge clk);
    a     = av;
    cin   = c;
    reset = r;
    @(posedge clk);
    #1;
    if (r) begin
      // Reset flushes the in-flight entries and clears the outputs right away.
      foreach (sb[i]) sb[i] = '{'0, '0, 1'b0};
      e = '{'0, '0, 1'b0};
      checkOutput({tag, "/rst_r1"}, res1, '0);
      checkOutput({tag, "/rst_r2"}, res2, '0);
`ifdef MODADD_RANGE_CHK_EN
      checkOutput({tag, "/rst_rerr"}, W'(rerr1), '0);
`endif
    end else begin
      e = '{model(av, c, M1), model(av, c, M2), (int'(av) >= M1)};
    end
    sb.push_back(e);
    if (sb.size() == 3) begin
      e = sb.pop_front();
      checkOutput({tag, "/r1"}, res1, e.r1);
      checkOutput({tag, "/r2"}, res2, e.r2);
`ifdef MODADD_RANGE_CHK_EN
      checkOutput({tag, "/rerr1"}, W'(rerr1), W'(e.re));
      checkOutput({tag, "/rerr2"}, W'(rerr2), '0);
`endif
    end
  endtask

  initial begin
    // Reset held for three cycles, then zeros are flushed through.
    applyStimulus(0, 1'b0, 1'b1, "reset");
    applyStimulus(0, 1'b0, 1'b1, "reset");
    applyStimulus(0, 1'b0, 1'b1, "reset");
    applyStimulus(0, 1'b0, 1'b0, "post_reset");
    applyStimulus(0, 1'b0, 1'b0, "post_reset");

    // Directed back-to-back values.
    applyStimulus(0,      1'b0, 1'b0, "zero");
    applyStimulus(177140, 1'b1, 1'b0, "mid");
    applyStimulus(177146, 1'b1, 1'b0, "wrap");
    applyStimulus(177146, 1'b0, 1'b0, "top");

    // Out-of-range operands and the power-of-two boundary cases.
    applyStimulus(261143, 1'b0, 1'b0, "oor_a");
    applyStimulus(262143, 1'b1, 1'b0, "oor_max");
    applyStimulus(177147, 1'b0, 1'b0, "oor_m");
    applyStimulus(5,      1'b1, 1'b0, "small");
    applyStimulus(262143, 1'b0, 1'b0, "max_nocin");
    applyStimulus(177140, 1'b1, 1'b0, "mid2");

    // Streaming, with a one-cycle reset while the pipeline is full.
    for (int i = 0; i < 1000; i += 9) begin
      applyStimulus(W'((i * i) % 262144), 1'(i % 2), 1'b0, "stream");
      if (i == 504) applyStimulus(W'(12345), 1'b1, 1'b1, "mid_reset");
    end

    // Drain the pipeline.
    applyStimulus(0, 1'b0, 1'b0, "drain");
    applyStimulus(0, 1'b0, 1'b0, "drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
